// File: rtl/pooling_row_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : pooling_row_sender_if
// Purpose  : Bundles the two data paths of the pooling row sender:
//            - upstream row handshake from the conv stage (valid/ready/data)
//            - downstream beat bus to the pooling layer (strobe, indices, data)
// Modports : master - the row sender (consumes rows, drives beats)
//            slave  - the environment (produces rows, observes beats)
// Revision : 1.0 - initial release
// ============================================================================
interface pooling_row_sender_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_SIZE      = 6,
  parameter int FEATURE_WIDTH = 3,
  parameter int ROW_WIDTH     = 3
);
  // Upstream row handshake
  logic                           in_valid;
  logic                           in_ready;
  logic [ROW_SIZE*DATA_WIDTH-1:0] in_data;

  // Downstream beat bus (no backpressure)
  logic                           input_valid;
  logic [FEATURE_WIDTH-1:0]       feature_idx;
  logic [ROW_WIDTH-1:0]           feature_row;
  logic [ROW_SIZE*DATA_WIDTH-1:0] data_out;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output input_valid, feature_idx, feature_row, data_out
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  input_valid, feature_idx, feature_row, data_out
  );
endinterface
`default_nettype wire

// File: rtl/pooling_row_sender.sv
`default_nettype none
// ============================================================================
// Module   : pooling_row_sender
// Purpose  : Transmit side of the pooling-layer row interface. Rows from the
//            conv stage are buffered in a small FIFO, then emitted to the
//            pooling layer as single-cycle beats in feature-major order
//            (feature 0 rows 0..NUM_ROW-1, feature 1, ...). A minimum idle gap
//            of GAP_CYCLES is enforced between beats since the pooling side
//            cannot stall.
// Ports    : clk         - clock, rising edge
//            rst         - asynchronous reset, active high
//            start       - one-cycle pulse, begins one frame (IDLE only)
//            busy        - high from accepted start until frame_done
//            frame_done  - one-cycle pulse in the cycle after the last beat
//            bus         - pooling_row_sender_if.master:
//                            in_valid/in_ready/in_data  upstream rows
//                            input_valid/feature_idx/feature_row/data_out
//                                                       beats to pooling
// Revision : 1.0 - initial release
// ============================================================================
module pooling_row_sender #(
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_SIZE      = 6,
  parameter int NUM_FEATURE   = 6,
  parameter int NUM_ROW       = 6,
  parameter int FEATURE_WIDTH = 3,
  parameter int ROW_WIDTH     = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  pooling_row_sender_if.master bus
);

  localparam int c_row_w = ROW_SIZE * DATA_WIDTH;
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [c_cnt_w-1:0]       c_depth        = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_gap_w-1:0]       c_gap_last     = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [FEATURE_WIDTH-1:0] c_last_feature = FEATURE_WIDTH'(NUM_FEATURE - 1);
  localparam logic [ROW_WIDTH-1:0]     c_last_row     = ROW_WIDTH'(NUM_ROW - 1);
  localparam bit                       c_has_gap      = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Row FIFO
  // --------------------------------------------------------------------------
  logic [c_row_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  state_t             r_state;

  logic               w_full;
  logic               w_push;
  logic               w_pop;

  // in_ready comes from the registered count only, so a pop in the same cycle
  // frees the slot one cycle later. This keeps in_ready free of FSM paths.
  assign w_full       = (r_count == c_depth);
  assign w_push       = bus.in_valid && !w_full;
  assign w_pop        = (r_state == S_SEND) && (r_count != '0);
  assign bus.in_ready = !w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // --------------------------------------------------------------------------
  logic [FEATURE_WIDTH-1:0] r_fidx;
  logic [ROW_WIDTH-1:0]     r_ridx;
  logic [c_gap_w-1:0]       r_gap_cnt;
  logic                     r_input_valid;
  logic [FEATURE_WIDTH-1:0] r_feature_idx;
  logic [ROW_WIDTH-1:0]     r_feature_row;
  logic [c_row_w-1:0]       r_data_out;
  logic                     r_busy;
  logic                     r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fidx        <= '0;
      r_ridx        <= '0;
      r_gap_cnt     <= '0;
      r_input_valid <= 1'b0;
      r_feature_idx <= '0;
      r_feature_row <= '0;
      r_data_out    <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      // Strobes default low; index and data registers hold between beats.
      r_input_valid <= 1'b0;
      r_frame_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SEND;
            r_fidx  <= '0;
            r_ridx  <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_SEND: begin
          // Starvation simply waits here with counters frozen.
          if (w_pop) begin
            r_input_valid <= 1'b1;
            r_data_out    <= r_mem[r_rd_ptr];
            r_feature_idx <= r_fidx;
            r_feature_row <= r_ridx;

            if (r_ridx == c_last_row) begin
              r_ridx <= '0;
              r_fidx <= r_fidx + 1'b1;
            end else begin
              r_ridx <= r_ridx + 1'b1;
            end

            if ((r_fidx == c_last_feature) && (r_ridx == c_last_row)) begin
              r_state <= S_DONE;
            end else if (c_has_gap) begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.input_valid = r_input_valid;
  assign bus.feature_idx = r_feature_idx;
  assign bus.feature_row = r_feature_row;
  assign bus.data_out    = r_data_out;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pooling_row_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_pooling_row_sender
// Purpose  : Self-checking bench for pooling_row_sender. Two instances are
//            used: dut0 with the default gap of one cycle and dut1 with no gap.
//            Rows carry random data; expected beats are derived from the
//            order rows were accepted (beat k = feature k/NUM_ROW,
//            row k%NUM_ROW, k-th accepted row).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pooling_row_sender;

  localparam int DW    = 32;
  localparam int RS    = 6;
  localparam int NF    = 6;
  localparam int NR    = 6;
  localparam int FW    = 3;
  localparam int RW    = 3;
  localparam int DEPTH = 4;
  localparam int ROWW  = RS * DW;
  localparam int TOTAL = NF * NR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy0, busy1, done0, done1;

  pooling_row_sender_if #(.DATA_WIDTH(DW), .ROW_SIZE(RS), .FEATURE_WIDTH(FW), .ROW_WIDTH(RW)) ifc0 ();
  pooling_row_sender_if #(.DATA_WIDTH(DW), .ROW_SIZE(RS), .FEATURE_WIDTH(FW), .ROW_WIDTH(RW)) ifc1 ();

  pooling_row_sender #(
    .DATA_WIDTH(DW), .ROW_SIZE(RS), .NUM_FEATURE(NF), .NUM_ROW(NR),
    .FEATURE_WIDTH(FW), .ROW_WIDTH(RW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .frame_done(done0), .bus(ifc0)
  );

  pooling_row_sender #(
    .DATA_WIDTH(DW), .ROW_SIZE(RS), .NUM_FEATURE(NF), .NUM_ROW(NR),
    .FEATURE_WIDTH(FW), .ROW_WIDTH(RW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .frame_done(done1), .bus(ifc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [FW-1:0]   f;
    logic [RW-1:0]   r;
    logic [ROWW-1:0] d;
  } beat_t;

  beat_t           beats0[$], beats1[$];
  int              dones0[$], dones1[$];
  logic [ROWW-1:0] pushed0[$], pushed1[$];
  int              cyc   = 0;
  int              n_err = 0;
  int              n_chk = 0;

  // Beat/frame_done monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin : mon
    beat_t b;
    #1;
    cyc++;
    if (ifc0.input_valid === 1'b1) begin
      b.cyc = cyc; b.f = ifc0.feature_idx; b.r = ifc0.feature_row; b.d = ifc0.data_out;
      beats0.push_back(b);
    end
    if (ifc1.input_valid === 1'b1) begin
      b.cyc = cyc; b.f = ifc1.feature_idx; b.r = ifc1.feature_row; b.d = ifc1.data_out;
      beats1.push_back(b);
    end
    if (done0 === 1'b1) dones0.push_back(cyc);
    if (done1 === 1'b1) dones1.push_back(cyc);
  end

  function automatic logic [ROWW-1:0] rand_row();
    logic [ROWW-1:0] r;
    for (int i = 0; i < RS; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  // Pushes n random rows; optional idle pause before row index pause_after.
  // Called and returns just after a falling edge.
  task automatic push_rows(input int which, input int n, input int pause_after, input int pause_len);
    logic [ROWW-1:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == pause_after) begin
        if (which == 0) ifc0.in_valid = 1'b0; else ifc1.in_valid = 1'b0;
        repeat (pause_len) @(negedge clk);
      end
      d = rand_row();
      if (which == 0) begin ifc0.in_valid = 1'b1; ifc0.in_data = d; end
      else            begin ifc1.in_valid = 1'b1; ifc1.in_data = d; end
      t = 0;
      while (((which == 0) ? ifc0.in_ready : ifc1.in_ready) !== 1'b1 && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        n_chk++; n_err++;
        $display("FAIL push_accept dut%0d row%0d: in_ready low for %0d cycles, required 1", which, i, t);
        if (which == 0) ifc0.in_valid = 1'b0; else ifc1.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (which == 0) pushed0.push_back(d); else pushed1.push_back(d);
    end
    if (which == 0) ifc0.in_valid = 1'b0; else ifc1.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (which == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int target);
    int t = 0;
    while (((which == 0) ? dones0.size() : dones1.size()) < target && t < 800) begin
      @(negedge clk);
      t++;
    end
    if (t >= 800) begin
      n_chk++; n_err++;
      $display("FAIL frame_done_timeout dut%0d: no frame_done within %0d cycles", which, t);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ifc0.input_valid !== 1'b0 || ifc0.feature_idx !== '0 || ifc0.feature_row !== '0 ||
        ifc0.data_out !== '0 || busy0 !== 1'b0 || done0 !== 1'b0 || ifc0.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: iv=%b f=%0d r=%0d d=%h busy=%b done=%b rdy=%b, required all 0 and rdy=1",
               ifc0.input_valid, ifc0.feature_idx, ifc0.feature_row, ifc0.data_out, busy0, done0, ifc0.in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (ifc0.input_valid !== 1'b0 || ifc1.input_valid !== 1'b0 || busy0 !== 1'b0) begin
        n_err++;
        $display("FAIL idle_quiet cycle%0d: iv0=%b iv1=%b busy=%b, required 0", i, ifc0.input_valid, ifc1.input_valid, busy0);
      end
    end
  endtask

  task automatic test_frame_default();
    beats0.delete(); dones0.delete(); pushed0.delete();
    fork
      push_rows(0, TOTAL, -1, 0);
      begin
        pulse_start(0);
        n_chk++;
        if (busy0 !== 1'b1) begin n_err++; $display("FAIL t2_busy: busy=%b, required 1", busy0); end
        wait_done(0, 1);
      end
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (beats0.size() !== TOTAL) begin n_err++; $display("FAIL t2_count: beats=%0d, required %0d", beats0.size(), TOTAL); end
    for (int k = 0; k < beats0.size() && k < pushed0.size(); k++) begin
      n_chk++;
      if (int'(beats0[k].f) !== k / NR || int'(beats0[k].r) !== k % NR || beats0[k].d !== pushed0[k]) begin
        n_err++;
        $display("FAIL t2_beat%0d: got f=%0d r=%0d d=%h, required f=%0d r=%0d d=%h",
                 k, beats0[k].f, beats0[k].r, beats0[k].d, k / NR, k % NR, pushed0[k]);
      end
      if (k > 0) begin
        n_chk++;
        if (beats0[k].cyc - beats0[k-1].cyc !== 2) begin
          n_err++;
          $display("FAIL t2_spacing%0d: got %0d cycles, required 2", k, beats0[k].cyc - beats0[k-1].cyc);
        end
      end
    end
    n_chk++;
    if (dones0.size() !== 1) begin
      n_err++; $display("FAIL t2_done_count: got %0d, required 1", dones0.size());
    end else if (beats0.size() > 0) begin
      n_chk++;
      if (dones0[0] !== beats0[beats0.size()-1].cyc + 1) begin
        n_err++; $display("FAIL t2_done_time: got cycle %0d, required %0d", dones0[0], beats0[beats0.size()-1].cyc + 1);
      end
    end
    n_chk++;
    if (busy0 !== 1'b0) begin n_err++; $display("FAIL t2_busy_end: busy=%b, required 0", busy0); end
  endtask

  task automatic test_backpressure();
    logic [ROWW-1:0] d5;
    int t, acc;
    beats0.delete(); dones0.delete(); pushed0.delete();
    push_rows(0, DEPTH, -1, 0);
    n_chk++;
    if (ifc0.in_ready !== 1'b0) begin n_err++; $display("FAIL t3_full: in_ready=%b, required 0", ifc0.in_ready); end
    d5 = rand_row();
    ifc0.in_valid = 1'b1; ifc0.in_data = d5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (ifc0.in_ready !== 1'b0 || beats0.size() !== 0) begin
        n_err++; $display("FAIL t3_held: in_ready=%b beats=%0d, required 0 and 0", ifc0.in_ready, beats0.size());
      end
    end
    pulse_start(0);
    t = 0;
    while (ifc0.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_chk++; n_err++; $display("FAIL t3_ready_timeout: in_ready stayed 0"); end
    @(negedge clk);
    acc = cyc;
    pushed0.push_back(d5);
    ifc0.in_valid = 1'b0;
    n_chk++;
    if (beats0.size() < 1 || acc !== beats0[0].cyc + 1) begin
      n_err++;
      $display("FAIL t3_fifth_accept: accepted at cycle %0d, required first pop + 1 (beats=%0d)", acc, beats0.size());
    end
    fork
      push_rows(0, TOTAL - DEPTH - 1, -1, 0);
      wait_done(0, 1);
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (beats0.size() !== TOTAL) begin n_err++; $display("FAIL t3_count: beats=%0d, required %0d", beats0.size(), TOTAL); end
    for (int k = 0; k < beats0.size() && k < pushed0.size(); k++) begin
      n_chk++;
      if (int'(beats0[k].f) !== k / NR || int'(beats0[k].r) !== k % NR || beats0[k].d !== pushed0[k]) begin
        n_err++;
        $display("FAIL t3_beat%0d: got f=%0d r=%0d d=%h, required f=%0d r=%0d d=%h",
                 k, beats0[k].f, beats0[k].r, beats0[k].d, k / NR, k % NR, pushed0[k]);
      end
    end
  endtask

  task automatic test_starvation();
    beats0.delete(); dones0.delete(); pushed0.delete();
    fork
      push_rows(0, TOTAL, 7, 10);
      begin pulse_start(0); wait_done(0, 1); end
      begin
        int t = 0;
        int idle = 0;
        while (beats0.size() < 7 && t < 300) begin @(negedge clk); t++; end
        @(negedge clk);
        t = 0;
        while (beats0.size() == 7 && t < 100) begin
          n_chk++;
          if (ifc0.input_valid !== 1'b0 || ifc0.feature_idx !== 3'd1 || ifc0.feature_row !== 3'd0 ||
              ifc0.data_out !== pushed0[6]) begin
            n_err++;
            $display("FAIL t4_hold: iv=%b f=%0d r=%0d, required iv=0 f=1 r=0 with row 7 data",
                     ifc0.input_valid, ifc0.feature_idx, ifc0.feature_row);
          end
          idle++;
          @(negedge clk);
          t++;
        end
        n_chk++;
        if (idle < 3) begin n_err++; $display("FAIL t4_stall_len: idle %0d cycles, required >= 3", idle); end
      end
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (beats0.size() < 8 || beats0[7].f !== 3'd1 || beats0[7].r !== 3'd1 || pushed0.size() < 8 || beats0[7].d !== pushed0[7]) begin
      n_err++; $display("FAIL t4_resume: beat 8 not (1,1) with row 8 data (beats=%0d)", beats0.size());
    end
    n_chk++;
    if (beats0.size() !== TOTAL || dones0.size() !== 1) begin
      n_err++; $display("FAIL t4_count: beats=%0d dones=%0d, required %0d and 1", beats0.size(), dones0.size(), TOTAL);
    end
    for (int k = 0; k < beats0.size() && k < pushed0.size(); k++) begin
      n_chk++;
      if (int'(beats0[k].f) !== k / NR || int'(beats0[k].r) !== k % NR || beats0[k].d !== pushed0[k]) begin
        n_err++;
        $display("FAIL t4_beat%0d: got f=%0d r=%0d, required f=%0d r=%0d", k, beats0[k].f, beats0[k].r, k / NR, k % NR);
      end
    end
  endtask

  task automatic test_start_ignored();
    beats0.delete(); dones0.delete(); pushed0.delete();
    fork
      push_rows(0, TOTAL, -1, 0);
      begin
        int t = 0;
        pulse_start(0);
        while (beats0.size() < 15 && t < 300) begin @(negedge clk); t++; end
        pulse_start(0);
        wait_done(0, 1);
      end
    join
    repeat (10) @(negedge clk);
    n_chk++;
    if (beats0.size() !== TOTAL || dones0.size() !== 1 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL t5_restart_ignored: beats=%0d dones=%0d busy=%b, required %0d, 1, 0",
               beats0.size(), dones0.size(), busy0, TOTAL);
    end
    for (int k = 0; k < beats0.size() && k < pushed0.size(); k++) begin
      n_chk++;
      if (int'(beats0[k].f) !== k / NR || int'(beats0[k].r) !== k % NR || beats0[k].d !== pushed0[k]) begin
        n_err++;
        $display("FAIL t5_beat%0d: got f=%0d r=%0d, required f=%0d r=%0d", k, beats0[k].f, beats0[k].r, k / NR, k % NR);
      end
    end
  endtask

  task automatic test_reset_abort();
    beats0.delete(); dones0.delete(); pushed0.delete();
    fork
      push_rows(0, 12, -1, 0);
      begin
        int t = 0;
        pulse_start(0);
        while (beats0.size() < 10 && t < 300) begin @(negedge clk); t++; end
      end
    join
    rst = 1'b1;
    #1;
    n_chk++;
    if (ifc0.input_valid !== 1'b0 || ifc0.feature_idx !== '0 || ifc0.feature_row !== '0 ||
        ifc0.data_out !== '0 || busy0 !== 1'b0 || done0 !== 1'b0 || ifc0.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t5_abort_state: iv=%b f=%0d r=%0d busy=%b done=%b rdy=%b, required zeros and rdy=1",
               ifc0.input_valid, ifc0.feature_idx, ifc0.feature_row, busy0, done0, ifc0.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    pushed0.delete(); beats0.delete();
    repeat (10) @(negedge clk);
    n_chk++;
    if (dones0.size() !== 0 || beats0.size() !== 0) begin
      n_err++; $display("FAIL t5_abort_quiet: dones=%0d beats=%0d, required 0 and 0", dones0.size(), beats0.size());
    end
    fork
      push_rows(0, TOTAL, -1, 0);
      begin pulse_start(0); wait_done(0, 1); end
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (beats0.size() !== TOTAL || dones0.size() !== 1) begin
      n_err++; $display("FAIL t5_new_frame: beats=%0d dones=%0d, required %0d and 1", beats0.size(), dones0.size(), TOTAL);
    end
    for (int k = 0; k < beats0.size() && k < pushed0.size(); k++) begin
      n_chk++;
      if (int'(beats0[k].f) !== k / NR || int'(beats0[k].r) !== k % NR || beats0[k].d !== pushed0[k]) begin
        n_err++;
        $display("FAIL t5_post_reset_beat%0d: got f=%0d r=%0d, required f=%0d r=%0d", k, beats0[k].f, beats0[k].r, k / NR, k % NR);
      end
    end
  endtask

  task automatic test_back_to_back();
    beats1.delete(); dones1.delete(); pushed1.delete();
    push_rows(1, DEPTH, -1, 0);
    n_chk++;
    if (ifc1.in_ready !== 1'b0) begin n_err++; $display("FAIL t6_prefill: in_ready=%b, required 0", ifc1.in_ready); end
    fork
      push_rows(1, TOTAL - DEPTH, -1, 0);
      begin pulse_start(1); wait_done(1, 1); end
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (beats1.size() !== TOTAL) begin n_err++; $display("FAIL t6_count: beats=%0d, required %0d", beats1.size(), TOTAL); end
    for (int k = 0; k < beats1.size() && k < pushed1.size(); k++) begin
      n_chk++;
      if (int'(beats1[k].f) !== k / NR || int'(beats1[k].r) !== k % NR || beats1[k].d !== pushed1[k]) begin
        n_err++;
        $display("FAIL t6_beat%0d: got f=%0d r=%0d d=%h, required f=%0d r=%0d d=%h",
                 k, beats1[k].f, beats1[k].r, beats1[k].d, k / NR, k % NR, pushed1[k]);
      end
      if (k > 0) begin
        n_chk++;
        if (beats1[k].cyc - beats1[k-1].cyc !== 1) begin
          n_err++;
          $display("FAIL t6_spacing%0d: got %0d cycles, required 1", k, beats1[k].cyc - beats1[k-1].cyc);
        end
      end
    end
    n_chk++;
    if (dones1.size() !== 1 || beats1.size() == 0) begin
      n_err++; $display("FAIL t6_done_count: got %0d, required 1", dones1.size());
    end else if (dones1[0] !== beats1[beats1.size()-1].cyc + 1) begin
      n_err++; $display("FAIL t6_done_time: got cycle %0d, required %0d", dones1[0], beats1[beats1.size()-1].cyc + 1);
    end
  endtask

  initial begin
    ifc0.in_valid = 1'b0; ifc0.in_data = '0;
    ifc1.in_valid = 1'b0; ifc1.in_data = '0;
    test_reset();
    test_frame_default();
    test_backpressure();
    test_starvation();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
